// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: register offsets and shared widths for the interrupt controller.
package int_ctrl_pkg;
  localparam int INT_BUS = 8;
  localparam logic [INT_BUS-1:0] INT_NONE = '0;
  localparam int DATA_W = 32;
  localparam logic [2:0] INT_CTRL_ENABLE    = 3'd0;
  localparam logic [2:0] INT_CTRL_PENDING   = 3'd1;
  localparam logic [2:0] INT_CTRL_MODE      = 3'd2;
  localparam logic [2:0] INT_CTRL_CLAIM     = 3'd3;
  localparam logic [2:0] INT_CTRL_COMPLETE  = 3'd4;
  localparam logic [2:0] INT_CTRL_INSERVICE = 3'd5;
endpackage

// File: rtl/int_ctrl_if.sv
// int_ctrl_if: peripheral bus register port of the interrupt controller.
interface int_ctrl_if;
  import int_ctrl_pkg::*;
  logic              req_i;
  logic              we_i;
  logic [DATA_W-1:0] addr_i;
  logic [DATA_W-1:0] data_i;
  logic [DATA_W-1:0] data_o;
  modport master (output req_i, we_i, addr_i, data_i, input data_o);
  modport slave  (input req_i, we_i, addr_i, data_i, output data_o);
endinterface

// File: rtl/int_ctrl_src.sv
// int_ctrl_src: per-source detect plus pending/in-service flops.
// INT_CTRL_SYNC_EN adds a 2-flop synchroniser in front of edge/level detection.
module int_ctrl_src (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  input  logic mode,
  input  logic w1c,
  input  logic claim,
  input  logic complete,
  output logic pending,
  output logic in_service
);
  logic s, s_d, set;
`ifdef INT_CTRL_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync <= '0;
    else      sync <= {sync[0], irq};
  end
  assign s = sync[1];
`else
  assign s = irq;
`endif
  assign set = mode ? s & ~s_d : s;
  // a set event outranks a same-cycle clear, so no edge or level is lost
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_d        <= 1'b0;
      pending    <= 1'b0;
      in_service <= 1'b0;
    end else begin
      s_d        <= s;
      pending    <= set | (pending & ~(w1c | claim));
      in_service <= claim | (in_service & ~complete);
    end
  end
endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: platform interrupt controller with claim/complete register port.
// Define INT_CTRL_SYNC_EN to synchronise asynchronous irq_i lines.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_i,
  int_ctrl_if.slave          bus,
  output logic [INT_BUS-1:0] int_flag_o
);
  logic [NUM_SRC-1:0] enable, mode, pending, in_service, ready, w1c, claim, complete;
  logic [2:0] sel;
  logic [3:0] claim_id;
  logic wr, unused;
  assign unused = ^{bus.addr_i[DATA_W-1:5], bus.addr_i[1:0]};
  assign sel = bus.addr_i[4:2];
  assign wr = bus.req_i & bus.we_i;
  assign ready = pending & enable & ~in_service;
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign w1c[i]      = wr && sel == INT_CTRL_PENDING && bus.data_i[i];
    assign claim[i]    = wr && sel == INT_CTRL_CLAIM && bus.data_i == 32'(i + 1) && ready[i];
    assign complete[i] = wr && sel == INT_CTRL_COMPLETE && bus.data_i == 32'(i + 1) && in_service[i];
    int_ctrl_src u_src (
      .clk        (clk),
      .rst        (rst),
      .irq        (irq_i[i]),
      .mode       (mode[i]),
      .w1c        (w1c[i]),
      .claim      (claim[i]),
      .complete   (complete[i]),
      .pending    (pending[i]),
      .in_service (in_service[i])
    );
  end
  // scan downward so the lowest ready ID is the last one written
  always_comb begin
    claim_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) if (ready[i]) claim_id = 4'(i + 1);
  end
  assign bus.data_o = sel == INT_CTRL_ENABLE    ? 32'(enable)     :
                      sel == INT_CTRL_PENDING   ? 32'(pending)    :
                      sel == INT_CTRL_MODE      ? 32'(mode)       :
                      sel == INT_CTRL_CLAIM     ? 32'(claim_id)   :
                      sel == INT_CTRL_INSERVICE ? 32'(in_service) : '0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable     <= '0;
      mode       <= '0;
      int_flag_o <= INT_NONE;
    end else begin
      if (wr && sel == INT_CTRL_ENABLE) enable <= bus.data_i[NUM_SRC-1:0];
      if (wr && sel == INT_CTRL_MODE)   mode   <= bus.data_i[NUM_SRC-1:0];
      int_flag_o <= INT_BUS'(ready);
    end
  end
endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed self-checking bench for int_ctrl (either sync build).
module tb_int_ctrl;
  import int_ctrl_pkg::*;
`ifdef INT_CTRL_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam logic [31:0] A_EN = 32'h00, A_PEND = 32'h04, A_MODE = 32'h08,
                          A_CLAIM = 32'h0C, A_COMP = 32'h10, A_INS = 32'h14, A_BAD = 32'h18;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] irq;
  logic [7:0] flag;
  int vectors = 0;
  int errors = 0;
  int_ctrl_if bus ();
  int_ctrl #(.NUM_SRC(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_i      (irq),
    .bus        (bus),
    .int_flag_o (flag)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = a; bus.data_i = d;
    step(1);
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.data_i = '0;
  endtask
  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.we_i = 1'b0; bus.addr_i = a;
    #1;
    chk(tag, bus.data_o, exp);
  endtask
  initial begin
    rst = 1'b0; irq = 8'hFF;
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.data_i = '0;
    step(3);
    chk("reset flag", 32'(flag), 32'h0);
    rd("reset enable", A_EN, 0);
    rd("reset pending", A_PEND, 0);
    rd("reset mode", A_MODE, 0);
    rd("reset claim", A_CLAIM, 0);
    rd("reset inservice", A_INS, 0);
    rd("unmapped", A_BAD, 0);
    irq = 8'h00; rst = 1'b1;
    wr(A_EN, 32'h01);
    wr(A_MODE, 32'h00);
    irq = 8'h01;
    step(1 + LAT);
    chk("latency early", 32'(flag), 32'h00);
    step(1);
    chk("latency flag", 32'(flag), 32'h01);
    rd("enable rb", A_EN, 32'h01);
    irq = 8'h00;
    step(1 + LAT);
    wr(A_PEND, 32'h01);
    rd("w1c level", A_PEND, 0);
    step(1);
    chk("w1c flag", 32'(flag), 32'h00);
    wr(A_MODE, 32'h04);
    wr(A_EN, 32'h04);
    rd("mode rb", A_MODE, 32'h04);
    irq = 8'h04; step(1); irq = 8'h00;
    step(1 + LAT);
    rd("edge pending", A_PEND, 32'h04);
    rd("edge claim rd", A_CLAIM, 3);
    chk("edge flag", 32'(flag), 32'h04);
    wr(A_CLAIM, 3);
    rd("claim inservice", A_INS, 32'h04);
    rd("claim pending", A_PEND, 0);
    rd("claim rd after", A_CLAIM, 0);
    step(1);
    chk("claim flag", 32'(flag), 32'h00);
    irq = 8'h04; step(1); irq = 8'h00;
    step(1 + LAT);
    rd("second edge", A_PEND, 32'h04);
    chk("masked flag", 32'(flag), 32'h00);
    wr(A_COMP, 3);
    rd("complete inservice", A_INS, 0);
    rd("complete claim rd", A_CLAIM, 3);
    step(1);
    chk("complete flag", 32'(flag), 32'h04);
    wr(A_CLAIM, 3);
    wr(A_COMP, 3);
    wr(A_MODE, 32'h22);
    wr(A_EN, 32'h22);
    irq = 8'h22; step(1); irq = 8'h00;
    step(1 + LAT);
    rd("prio claim 2", A_CLAIM, 2);
    chk("two flags", 32'(flag), 32'h22);
    wr(A_CLAIM, 2);
    rd("prio claim 6", A_CLAIM, 6);
    step(1);
    chk("flag src5", 32'(flag), 32'h20);
    wr(A_CLAIM, 6);
    wr(A_COMP, 2);
    wr(A_COMP, 6);
    rd("all complete", A_INS, 0);
    irq = 8'h22; step(1); irq = 8'h00;
    step(1 + LAT);
    wr(A_CLAIM, 6);
    wr(A_CLAIM, 0);
    wr(A_CLAIM, 9);
    wr(A_CLAIM, 4);
    wr(A_CLAIM, 6);
    wr(A_COMP, 2);
    wr(A_COMP, 0);
    wr(A_COMP, 9);
    rd("illegal pending", A_PEND, 32'h02);
    rd("illegal inservice", A_INS, 32'h20);
    rd("illegal claim rd", A_CLAIM, 2);
    chk("illegal flag", 32'(flag), 32'h02);
    wr(A_PEND, 32'h02);
    rd("w1c edge clear", A_PEND, 0);
    irq = 8'h02;
    step(LAT);
    wr(A_PEND, 32'h02);
    rd("set beats w1c", A_PEND, 32'h02);
    irq = 8'h00;
    step(1 + LAT);
    wr(A_PEND, 32'hFF);
    wr(A_MODE, 32'h00);
    wr(A_EN, 32'h01);
    irq = 8'h01;
    step(2 + LAT);
    chk("level flag", 32'(flag), 32'h01);
    rd("level claim rd", A_CLAIM, 1);
    wr(A_CLAIM, 1);
    rd("level stays pending", A_PEND, 32'h01);
    rd("level inservice", A_INS, 32'h21);
    step(1);
    chk("level masked", 32'(flag), 32'h00);
    irq = 8'h00;
    step(1 + LAT);
    wr(A_PEND, 32'h01);
    wr(A_COMP, 1);
    rd("level cleared", A_PEND, 0);
    rd("level completed", A_INS, 32'h20);
    step(1);
    chk("level final flag", 32'(flag), 32'h00);
    wr(A_EN, 32'hFF);
    irq = 8'h10;
    step(2 + LAT);
    chk("pre-reset flag", 32'(flag), 32'h10);
    #2 rst = 1'b0;
    #1;
    chk("async reset flag", 32'(flag), 32'h00);
    rd("async reset inservice", A_INS, 0);
    irq = 8'h00; rst = 1'b1;
    step(1);
    rd("post reset inservice", A_INS, 0);
    rd("post reset enable", A_EN, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
